// File: rtl/sub_serial.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock through one borrow register.
// Optional macro SUB_SERIAL_SAT_EN saturates diff to the signed limit on overflow.
module sub_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_a, dig_b, dig_d;
    logic             br, br_msb;
    int               base;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid holds (with stable data) until out_ready, in_ready depends only on state.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

    always_comb begin
        base   = int'(cnt_q) * DIGIT;
        dig_a  = DIGIT'(a_q >> base);
        dig_b  = DIGIT'(b_q >> base);
        dig_d  = '0;
        br     = borrow_q;
        br_msb = 1'b0;
        // Bit-level ripple inside the digit; the borrow into the top bit feeds ovf.
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) br_msb = br;
            dig_d[i] = dig_a[i] ^ dig_b[i] ^ br;
            br       = (~dig_a[i] & dig_b[i]) | (~(dig_a[i] ^ dig_b[i]) & br);
        end

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                res_d    = (res_q & ~(DMASK << base)) | (WIDTH'(dig_d) << base);
                borrow_d = br;
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    bout_d  = br;
                    ovf_d   = br_msb ^ br;
                    diff_d  = res_d;
`ifdef SUB_SERIAL_SAT_EN
                    if (ovf_d) begin
                        diff_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
